// File: rtl/sys_bus_ctrl_burst.sv
// ---------------------------------------------------------------------------
// sys_bus_ctrl_burst
//
// Bursting system bus controller. The host latches a start address and a
// burst length with ale_en, then starts a read or a write of 1..2^BL_W beats.
// Each beat holds the slave strobe until io_ack; the address auto-increments
// between beats (wrapping modulo 2^ADDR_W). A beat that waits more than
// TIMEOUT cycles for io_ack aborts the burst and raises the sticky bus_err.
//
// Handshake: a beat is a strobe (io_write_en / io_read_en) held high by the
// controller until the slave answers with io_ack=1 at a rising edge; that
// edge completes the beat, there is no back-pressure on the host side other
// than bus_ready (high only in IDLE).
//
// Ports
//   clk, rst            clock (rising edge), async active-high reset
//   ale_en              latch addr_input/burst_len (IDLE or ADDR only)
//   bus_read_en         start a read burst (ADDR only)
//   bus_write_en        start a write burst (ADDR only)
//   burst_len           beats minus 1, sampled with ale_en
//   addr_input          start address, sampled with ale_en
//   data_write          host write data
//   data_read           last read beat data (registered)
//   data_valid          1-cycle pulse when data_read updated
//   beat_done           1-cycle pulse per acknowledged beat
//   bus_ready           high only in IDLE
//   bus_err             sticky error, cleared by ale_en in IDLE
//   state_now           current state code (debug)
//   state_nxt           next state code, combinational (debug)
//   bus_addr            slave address (registered)
//   bus_data_write      slave write data (registered)
//   io_write_en         slave write strobe, high in WRITE
//   io_read_en          slave read strobe, high in READ
//   io_data_read        slave read data, valid with io_ack
//   io_ack              slave beat acknowledge
// ---------------------------------------------------------------------------
module sys_bus_ctrl_burst #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int BL_W    = 3,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ale_en,
  input  logic              bus_read_en,
  input  logic              bus_write_en,
  input  logic [BL_W-1:0]   burst_len,
  input  logic [ADDR_W-1:0] addr_input,
  input  logic [DATA_W-1:0] data_write,
  output logic [DATA_W-1:0] data_read,
  output logic              data_valid,
  output logic              beat_done,
  output logic              bus_ready,
  output logic              bus_err,
  output logic [2:0]        state_now,
  output logic [2:0]        state_nxt,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_data_write,
  output logic              io_write_en,
  output logic              io_read_en,
  input  logic [DATA_W-1:0] io_data_read,
  input  logic              io_ack
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_WRITE = 3'd2,
    S_READ  = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_e;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_e            state_q, state_d;
  logic [BL_W-1:0]   beat_cnt_q;
  logic [7:0]        wait_cnt_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [DATA_W-1:0] bus_data_write_q;
  logic [DATA_W-1:0] data_read_q;
  logic              data_valid_q;
  logic              beat_done_q;
  logic              bus_err_q;

  logic in_beat;
  logic last_beat;
  logic timed_out;

  assign in_beat   = (state_q == S_WRITE) || (state_q == S_READ);
  assign last_beat = (beat_cnt_q == '0);
  // An ack on the same edge as the timeout wins, hence the !io_ack term.
  assign timed_out = in_beat && !io_ack && (wait_cnt_q == TIMEOUT_C);

  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:  state_d = ale_en ? S_ADDR : S_IDLE;
      S_ADDR: begin
        if (ale_en)                            state_d = S_ADDR;
        else if (bus_write_en && bus_read_en)  state_d = S_ERR;
        else if (bus_write_en)                 state_d = S_WRITE;
        else if (bus_read_en)                  state_d = S_READ;
        else                                   state_d = S_ADDR;
      end
      S_WRITE, S_READ: begin
        if (io_ack)         state_d = last_beat ? S_DONE : state_q;
        else if (timed_out) state_d = S_ERR;
        else                state_d = state_q;
      end
      default: state_d = S_IDLE;  // DONE, ERR and unused codes
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= S_IDLE;
      beat_cnt_q       <= '0;
      wait_cnt_q       <= '0;
      bus_addr_q       <= '0;
      bus_data_write_q <= '0;
      data_read_q      <= '0;
      data_valid_q     <= 1'b0;
      beat_done_q      <= 1'b0;
      bus_err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_valid_q <= 1'b0;
      beat_done_q  <= 1'b0;
      // The wait counter only runs while a beat is outstanding.
      if (!in_beat) wait_cnt_q <= '0;

      case (state_q)
        S_IDLE: begin
          if (ale_en) begin
            bus_addr_q <= addr_input;
            beat_cnt_q <= burst_len;
            bus_err_q  <= 1'b0;
          end
        end
        S_ADDR: begin
          if (ale_en) begin
            bus_addr_q <= addr_input;
            beat_cnt_q <= burst_len;
          end else if (bus_write_en && bus_read_en) begin
            bus_err_q <= 1'b1;
          end else if (bus_write_en) begin
            bus_data_write_q <= data_write;
          end
        end
        S_WRITE, S_READ: begin
          if (io_ack) begin
            beat_done_q <= 1'b1;
            wait_cnt_q  <= '0;
            if (state_q == S_READ) begin
              data_read_q  <= io_data_read;
              data_valid_q <= 1'b1;
            end else begin
              // Host presents the next beat's data ahead of this ack.
              bus_data_write_q <= data_write;
            end
            if (!last_beat) begin
              beat_cnt_q <= beat_cnt_q - BL_W'(1);
              bus_addr_q <= bus_addr_q + ADDR_W'(1);
            end
          end else if (timed_out) begin
            bus_err_q  <= 1'b1;
            wait_cnt_q <= '0;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Strobes and bus_ready decode the state register only, so they are
  // glitch-free and fall immediately on async reset.
  assign io_write_en    = (state_q == S_WRITE);
  assign io_read_en     = (state_q == S_READ);
  assign bus_ready      = (state_q == S_IDLE);
  assign state_now      = state_q;
  assign state_nxt      = state_d;
  assign bus_addr       = bus_addr_q;
  assign bus_data_write = bus_data_write_q;
  assign data_read      = data_read_q;
  assign data_valid     = data_valid_q;
  assign beat_done      = beat_done_q;
  assign bus_err        = bus_err_q;

endmodule

// File: tb/tb_sys_bus_ctrl_burst.sv
module tb_sys_bus_ctrl_burst;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 8;
  localparam int BL_W    = 3;
  localparam int TIMEOUT = 15;

  localparam logic [2:0] S_IDLE = 3'd0, S_ADDR = 3'd1, S_WRITE = 3'd2,
                         S_READ = 3'd3, S_DONE = 3'd4, S_ERR = 3'd5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              ale_en, bus_read_en, bus_write_en, io_ack;
  logic [BL_W-1:0]   burst_len;
  logic [ADDR_W-1:0] addr_input;
  logic [DATA_W-1:0] data_write, io_data_read;
  logic [DATA_W-1:0] data_read, bus_data_write;
  logic              data_valid, beat_done, bus_ready, bus_err;
  logic              io_write_en, io_read_en;
  logic [2:0]        state_now, state_nxt;
  logic [ADDR_W-1:0] bus_addr;

  sys_bus_ctrl_burst #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BL_W(BL_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .ale_en(ale_en), .bus_read_en(bus_read_en),
    .bus_write_en(bus_write_en), .burst_len(burst_len), .addr_input(addr_input),
    .data_write(data_write), .data_read(data_read), .data_valid(data_valid),
    .beat_done(beat_done), .bus_ready(bus_ready), .bus_err(bus_err),
    .state_now(state_now), .state_nxt(state_nxt), .bus_addr(bus_addr),
    .bus_data_write(bus_data_write), .io_write_en(io_write_en),
    .io_read_en(io_read_en), .io_data_read(io_data_read), .io_ack(io_ack)
  );

  int checks = 0;
  int failures = 0;

  // Per-transaction plan used by the reference model / slave driver.
  int           wait_plan [8];
  logic [7:0]   wdata_plan[10];
  logic [7:0]   rdata_plan[8];

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- driver + reference model ----------------
  // Drives one full transaction and checks every cycle against the expected
  // behaviour: beat i uses address start+i mod 256; a beat waits wait_plan[i]
  // cycles; a wait beyond TIMEOUT aborts after TIMEOUT+1 strobe cycles.
  task automatic run_burst(input logic [7:0] addr, input int len_m1, input bit wr);
    logic [2:0] busy_st, exp_nxt;
    logic [7:0] exp_addr;
    bit         timed_out, acked;
    busy_st = wr ? S_WRITE : S_READ;
    ale_en = 1'b1; addr_input = addr; burst_len = 3'(len_m1);
    tick();
    ale_en = 1'b0;
    checks++;
    if (state_now !== S_ADDR) begin failures++; $display("FAIL addr_state: got %0d exp %0d", state_now, S_ADDR); end
    checks++;
    if (bus_addr !== addr) begin failures++; $display("FAIL addr_latch: got %h exp %h", bus_addr, addr); end
    checks++;
    if (bus_err !== 1'b0 || bus_ready !== 1'b0) begin failures++; $display("FAIL addr_flags: err=%b ready=%b exp 0 0", bus_err, bus_ready); end
    if (wr) begin bus_write_en = 1'b1; data_write = wdata_plan[0]; end
    else bus_read_en = 1'b1;
    tick();
    bus_write_en = 1'b0; bus_read_en = 1'b0;
    if (wr) data_write = wdata_plan[1];
    timed_out = 1'b0;
    for (int i = 0; i <= len_m1 && !timed_out; i++) begin
      exp_addr = addr + 8'(i);
      for (int w = 0; w <= TIMEOUT; w++) begin
        checks++;
        if (state_now !== busy_st || io_write_en !== wr || io_read_en !== !wr) begin
          failures++;
          $display("FAIL strobe: beat %0d wait %0d state=%0d we=%b re=%b exp state %0d wr=%b", i, w, state_now, io_write_en, io_read_en, busy_st, wr);
        end
        checks++;
        if (bus_addr !== exp_addr) begin failures++; $display("FAIL beat_addr: beat %0d got %h exp %h", i, bus_addr, exp_addr); end
        if (wr) begin
          checks++;
          if (bus_data_write !== wdata_plan[i]) begin failures++; $display("FAIL beat_wdata: beat %0d got %h exp %h", i, bus_data_write, wdata_plan[i]); end
        end
        acked = (w == wait_plan[i]);
        io_ack = acked;
        io_data_read = acked ? rdata_plan[i] : 8'($urandom_range(0, 255));
        if (acked) exp_nxt = (i == len_m1) ? S_DONE : busy_st;
        else if (w == TIMEOUT) exp_nxt = S_ERR;
        else exp_nxt = busy_st;
        #1;
        checks++;
        if (state_nxt !== exp_nxt) begin failures++; $display("FAIL state_nxt: beat %0d wait %0d got %0d exp %0d", i, w, state_nxt, exp_nxt); end
        tick();
        io_ack = 1'b0;
        if (acked) begin
          checks++;
          if (beat_done !== 1'b1) begin failures++; $display("FAIL beat_done: beat %0d got %b exp 1", i, beat_done); end
          checks++;
          if (data_valid !== !wr) begin failures++; $display("FAIL data_valid: beat %0d got %b exp %b", i, data_valid, !wr); end
          if (!wr) begin
            checks++;
            if (data_read !== rdata_plan[i]) begin failures++; $display("FAIL data_read: beat %0d got %h exp %h", i, data_read, rdata_plan[i]); end
          end else begin
            data_write = wdata_plan[i+2];
          end
          break;
        end
        checks++;
        if (beat_done !== 1'b0 || data_valid !== 1'b0) begin failures++; $display("FAIL wait_pulse: beat %0d done=%b valid=%b exp 0 0", i, beat_done, data_valid); end
        if (w == TIMEOUT) begin
          timed_out = 1'b1;
          checks++;
          if (state_now !== S_ERR || bus_err !== 1'b1) begin failures++; $display("FAIL timeout: state=%0d err=%b exp %0d 1", state_now, bus_err, S_ERR); end
          checks++;
          if (io_read_en !== 1'b0 || io_write_en !== 1'b0) begin failures++; $display("FAIL timeout_strobe: we=%b re=%b exp 0 0", io_write_en, io_read_en); end
        end
      end
    end
    if (!timed_out) begin
      checks++;
      if (state_now !== S_DONE || io_read_en !== 1'b0 || io_write_en !== 1'b0) begin
        failures++; $display("FAIL done: state=%0d we=%b re=%b exp %0d 0 0", state_now, io_write_en, io_read_en, S_DONE);
      end
    end
    tick();
    checks++;
    if (state_now !== S_IDLE || bus_ready !== 1'b1) begin failures++; $display("FAIL end_idle: state=%0d ready=%b exp 0 1", state_now, bus_ready); end
    checks++;
    if (bus_err !== timed_out) begin failures++; $display("FAIL end_err: got %b exp %b", bus_err, timed_out); end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    ale_en = 0; bus_read_en = 0; bus_write_en = 0; io_ack = 0;
    burst_len = '0; addr_input = '0; data_write = '0; io_data_read = '0;
    tick(); tick();
    checks++;
    if (state_now !== S_IDLE || bus_ready !== 1'b1 || state_nxt !== S_IDLE) begin
      failures++; $display("FAIL reset_state: state=%0d nxt=%0d ready=%b exp 0 0 1", state_now, state_nxt, bus_ready);
    end
    checks++;
    if ({data_read, data_valid, beat_done, bus_err, bus_addr, bus_data_write, io_write_en, io_read_en} !== '0) begin
      failures++; $display("FAIL reset_outputs: got nonzero addr=%h wd=%h rd=%h", bus_addr, bus_data_write, data_read);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (state_now !== S_IDLE) begin failures++; $display("FAIL reset_release: got %0d exp 0", state_now); end
  endtask

  task automatic test_idle_ignore();
    bus_read_en = 1'b1; bus_write_en = 1'b1;
    tick();
    bus_read_en = 1'b0; bus_write_en = 1'b0;
    checks++;
    if (state_now !== S_IDLE || bus_err !== 1'b0) begin failures++; $display("FAIL idle_ignore: state=%0d err=%b exp 0 0", state_now, bus_err); end
  endtask

  task automatic test_single_write();
    wait_plan[0] = 0; wdata_plan[0] = 8'hFF; wdata_plan[1] = 8'h00; wdata_plan[2] = 8'h00;
    run_burst(8'h04, 0, 1'b1);
  endtask

  task automatic test_single_read();
    wait_plan[0] = 2; rdata_plan[0] = 8'hA5;
    run_burst(8'h04, 0, 1'b0);
  endtask

  task automatic test_burst_wrap();
    for (int i = 0; i < 4; i++) wait_plan[i] = 0;
    wdata_plan[0] = 8'h11; wdata_plan[1] = 8'h22; wdata_plan[2] = 8'h33;
    wdata_plan[3] = 8'h44; wdata_plan[4] = 8'h00; wdata_plan[5] = 8'h00;
    run_burst(8'hFE, 3, 1'b1);
  endtask

  task automatic test_timeout();
    // Ack exactly at the limit still succeeds.
    wait_plan[0] = TIMEOUT; rdata_plan[0] = 8'h3C;
    run_burst(8'h10, 0, 1'b0);
    // No ack at all: error after TIMEOUT+1 strobe cycles, cleared by next ale.
    wait_plan[0] = 1000;
    run_burst(8'h11, 0, 1'b0);
    wait_plan[0] = 1; rdata_plan[0] = 8'h5A;
    run_burst(8'h12, 0, 1'b0);
  endtask

  task automatic test_conflict();
    ale_en = 1'b1; addr_input = 8'h30; burst_len = 3'd0;
    tick();
    ale_en = 1'b0; bus_read_en = 1'b1; bus_write_en = 1'b1;
    #1;
    checks++;
    if (state_nxt !== S_ERR) begin failures++; $display("FAIL conflict_nxt: got %0d exp %0d", state_nxt, S_ERR); end
    tick();
    bus_read_en = 1'b0; bus_write_en = 1'b0;
    checks++;
    if (state_now !== S_ERR || bus_err !== 1'b1 || io_read_en !== 1'b0 || io_write_en !== 1'b0) begin
      failures++; $display("FAIL conflict_err: state=%0d err=%b we=%b re=%b exp 5 1 0 0", state_now, bus_err, io_write_en, io_read_en);
    end
    tick();
    checks++;
    if (state_now !== S_IDLE || bus_err !== 1'b1) begin failures++; $display("FAIL conflict_sticky: state=%0d err=%b exp 0 1", state_now, bus_err); end
    tick();
    checks++;
    if (bus_err !== 1'b1) begin failures++; $display("FAIL conflict_hold: err=%b exp 1", bus_err); end
  endtask

  task automatic test_relatch();
    ale_en = 1'b1; addr_input = 8'h10; burst_len = 3'd3;
    tick();
    checks++;
    if (bus_err !== 1'b0) begin failures++; $display("FAIL relatch_errclr: got %b exp 0", bus_err); end
    // ADDR holds with no enable.
    ale_en = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    checks++;
    if (state_now !== S_ADDR) begin failures++; $display("FAIL addr_hold: got %0d exp 1", state_now); end
    // ale_en wins over an enable in the same cycle.
    ale_en = 1'b1; addr_input = 8'h20; burst_len = 3'd0; bus_read_en = 1'b1;
    tick();
    ale_en = 1'b0;
    checks++;
    if (state_now !== S_ADDR || bus_addr !== 8'h20) begin failures++; $display("FAIL relatch: state=%0d addr=%h exp 1 20", state_now, bus_addr); end
    tick();
    bus_read_en = 1'b0;
    checks++;
    if (io_read_en !== 1'b1 || bus_addr !== 8'h20) begin failures++; $display("FAIL relatch_beat: re=%b addr=%h exp 1 20", io_read_en, bus_addr); end
    io_ack = 1'b1; io_data_read = 8'h77;
    tick();
    io_ack = 1'b0;
    checks++;
    if (state_now !== S_DONE || data_read !== 8'h77) begin failures++; $display("FAIL relatch_len: state=%0d rd=%h exp 4 77", state_now, data_read); end
    tick();
  endtask

  task automatic test_reset_mid_burst();
    ale_en = 1'b1; addr_input = 8'h40; burst_len = 3'd3;
    tick();
    ale_en = 1'b0; bus_read_en = 1'b1;
    tick();
    bus_read_en = 1'b0;
    io_ack = 1'b1; io_data_read = 8'h01;
    tick();
    io_ack = 1'b0;
    tick();  // beat 2 waiting, strobe high
    checks++;
    if (io_read_en !== 1'b1 || bus_addr !== 8'h41) begin failures++; $display("FAIL mid_setup: re=%b addr=%h exp 1 41", io_read_en, bus_addr); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (io_read_en !== 1'b0 || state_now !== S_IDLE || bus_ready !== 1'b1) begin
      failures++; $display("FAIL async_reset: re=%b state=%0d ready=%b exp 0 0 1", io_read_en, state_now, bus_ready);
    end
    io_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (data_valid !== 1'b0 || beat_done !== 1'b0) begin failures++; $display("FAIL reset_pulse: valid=%b done=%b exp 0 0", data_valid, beat_done); end
    end
    io_ack = 1'b0; rst = 1'b0;
    tick();
    checks++;
    if (state_now !== S_IDLE || data_valid !== 1'b0) begin failures++; $display("FAIL post_reset: state=%0d valid=%b exp 0 0", state_now, data_valid); end
  endtask

  task automatic test_random();
    int len, r;
    bit wr;
    logic [7:0] a;
    for (int n = 0; n < 24; n++) begin
      a = 8'($urandom_range(0, 255));
      len = $urandom_range(0, 7);
      wr = 1'($urandom_range(0, 1));
      for (int i = 0; i < 10; i++) wdata_plan[i] = 8'($urandom_range(0, 255));
      for (int i = 0; i < 8; i++) begin
        rdata_plan[i] = 8'($urandom_range(0, 255));
        r = $urandom_range(0, 15);
        wait_plan[i] = (r == 0) ? TIMEOUT + 3 : (r == 1) ? TIMEOUT : $urandom_range(0, 3);
      end
      run_burst(a, len, wr);
      r = $urandom_range(0, 2);
      for (int k = 0; k < r; k++) tick();
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_idle_ignore();
    test_single_write();
    test_single_read();
    test_burst_wrap();
    test_timeout();
    test_conflict();
    test_relatch();
    test_reset_mid_burst();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
